// File: rtl/mips_write_buffer.sv
// mips_write_buffer: posted-write FIFO between the mips core and exmemory.
// Stores drain when the core is not reading; reads forward from the newest match.
module mips_write_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] memdata,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] adr_q [DEPTH];
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             drain;
  logic             drop;
  logic             enq;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign drain = !empty && !memread;
  assign drop  = memwrite && full && !drain;
  assign enq   = memwrite && !drop;

  // Memory port: core reads own the port, otherwise the head entry drains.
  always_comb begin
    mem_we  = 1'b0;
    mem_adr = adr;
    mem_wd  = writedata;
    if (drain) begin
      mem_we  = 1'b1;
      mem_adr = adr_q[rd_ptr];
      mem_wd  = dat_q[rd_ptr];
    end
  end

  // Forwarding: walk oldest to newest so the newest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = rd_ptr;
    memdata = mem_rd;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (CW'(k) < count && adr_q[idx] == adr)
        memdata = dat_q[idx];
    end
  end

  // Entry storage; contents are qualified by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (enq) begin
      adr_q[wr_ptr] <= adr;
      dat_q[wr_ptr] <= writedata;
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (enq)
        wr_ptr <= wr_ptr + PW'(1);
      if (drain)
        rd_ptr <= rd_ptr + PW'(1);
      case ({enq, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_write_buffer.sv
// tb_mips_write_buffer: directed checks of the posted-write buffer.
// A small word memory stands in for exmemory.
module tb_mips_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic [31:0] memdata;
  logic        mem_we;
  logic [31:0] mem_adr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        empty;
  logic        full;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [256];
  logic        wrote44 = 1'b0;

  mips_write_buffer #(.WIDTH(32), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .memread   (memread),
    .memwrite  (memwrite),
    .adr       (adr),
    .writedata (writedata),
    .memdata   (memdata),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_adr[7:0]];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_adr[7:0]] <= mem_wd;
    end
  end

  always @(posedge clk) begin
    if (mem_we && mem_adr == 32'd44)
      wrote44 <= 1'b1;
  end

  task automatic cyc(input logic rs, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    reset     = rs;
    memread   = rd;
    memwrite  = wr;
    adr       = a;
    writedata = d;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    memread   = 1'b0;
    memwrite  = 1'b1;
    adr       = 32'd5;
    writedata = 32'd77;

    // reset with a store held on the bus
    cyc(1, 0, 1, 5, 77);
    cyc(1, 0, 1, 5, 77);
    cyc(0, 1, 0, 5, 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_noentry", memdata, 0);

    // single store then read-back
    cyc(0, 0, 1, 255, 210);
    chk("st_we0", 32'(mem_we), 0);
    cyc(0, 1, 0, 255, 0);
    chk("st_fwd", memdata, 210);
    chk("st_we_rd", 32'(mem_we), 0);
    chk("st_nempty", 32'(empty), 0);
    cyc(0, 0, 0, 0, 0);
    chk("st_drain_we", 32'(mem_we), 1);
    chk("st_drain_adr", mem_adr, 255);
    chk("st_drain_wd", mem_wd, 210);
    cyc(0, 1, 0, 255, 0);
    chk("st_empty", 32'(empty), 1);
    chk("st_memrd", memdata, 210);

    // ordering and newest-wins
    cyc(0, 1, 1, 8, 1);
    cyc(0, 1, 1, 12, 2);
    cyc(0, 1, 1, 8, 3);
    cyc(0, 1, 0, 8, 0);
    chk("ord_rd8", memdata, 3);
    chk("ord_we_rd", 32'(mem_we), 0);
    cyc(0, 1, 0, 12, 0);
    chk("ord_rd12", memdata, 2);
    chk("ord_nfull", 32'(full), 0);
    cyc(0, 0, 0, 0, 0);
    chk("ord_d0_we", 32'(mem_we), 1);
    chk("ord_d0_adr", mem_adr, 8);
    chk("ord_d0_wd", mem_wd, 1);
    cyc(0, 0, 0, 0, 0);
    chk("ord_d1_adr", mem_adr, 12);
    chk("ord_d1_wd", mem_wd, 2);
    cyc(0, 0, 0, 0, 0);
    chk("ord_d2_adr", mem_adr, 8);
    chk("ord_d2_wd", mem_wd, 3);
    cyc(0, 1, 0, 8, 0);
    chk("ord_empty", 32'(empty), 1);
    chk("ord_mem8", memdata, 3);

    // full plus store
    cyc(0, 1, 1, 16, 10);
    cyc(0, 1, 1, 20, 11);
    cyc(0, 1, 1, 24, 12);
    cyc(0, 1, 1, 28, 13);
    cyc(0, 1, 0, 0, 0);
    chk("fp_full", 32'(full), 1);
    cyc(0, 0, 1, 40, 99);
    chk("fp_we", 32'(mem_we), 1);
    chk("fp_adr", mem_adr, 16);
    chk("fp_wd", mem_wd, 10);
    cyc(0, 1, 0, 40, 0);
    chk("fp_full2", 32'(full), 1);
    chk("fp_ovf", 32'(overflow), 0);
    chk("fp_fwd40", memdata, 99);
    cyc(0, 1, 0, 16, 0);
    chk("fp_mem16", memdata, 10);

    // overflow: store dropped while full and reading
    cyc(0, 1, 1, 44, 7);
    cyc(0, 1, 0, 44, 0);
    chk("ov_flag", 32'(overflow), 1);
    chk("ov_nofwd", memdata, 0);
    chk("ov_full", 32'(full), 1);
    cyc(0, 0, 0, 0, 0);
    chk("ov_d0_adr", mem_adr, 20);
    chk("ov_d0_wd", mem_wd, 11);
    cyc(0, 0, 0, 0, 0);
    chk("ov_d1_adr", mem_adr, 24);
    chk("ov_d1_wd", mem_wd, 12);
    cyc(0, 0, 0, 0, 0);
    chk("ov_d2_adr", mem_adr, 28);
    chk("ov_d2_wd", mem_wd, 13);
    cyc(0, 0, 0, 0, 0);
    chk("ov_d3_adr", mem_adr, 40);
    chk("ov_d3_wd", mem_wd, 99);
    cyc(0, 1, 0, 44, 0);
    chk("ov_empty", 32'(empty), 1);
    chk("ov_sticky", 32'(overflow), 1);
    chk("ov_mem44", memdata, 0);
    chk("ov_never44", 32'(wrote44), 0);

    // reset mid-drain with three entries pending
    cyc(0, 1, 1, 48, 1);
    cyc(0, 1, 1, 52, 2);
    cyc(0, 1, 1, 56, 3);
    cyc(0, 1, 1, 60, 4);
    cyc(0, 0, 0, 0, 0);
    chk("rd_we", 32'(mem_we), 1);
    chk("rd_adr", mem_adr, 48);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rd_post0_we", 32'(mem_we), 0);
    chk("rd_post_empty", 32'(empty), 1);
    chk("rd_post_ovf", 32'(overflow), 0);
    cyc(0, 0, 0, 0, 0);
    chk("rd_post1_we", 32'(mem_we), 0);
    cyc(0, 0, 0, 0, 0);
    chk("rd_post2_we", 32'(mem_we), 0);
    cyc(0, 1, 0, 56, 0);
    chk("rd_mem56", memdata, 0);
    cyc(0, 1, 0, 60, 0);
    chk("rd_mem60", memdata, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
